led_scan_controller: RTL
========================

LED_SCAN_CONTROLLER -- requirements
Module: led_scan_controller

Interface
REQ-001 SHALL have parameter PORT_BASE, default 8'h10, which is the port_id of the CTRL register; RATE is at PORT_BASE+1 and STATUS is at PORT_BASE+2.
REQ-002 SHALL have parameter PRESCALE_DIV, default 65536, which is the base prescaler period in clk cycles (legal range 2..2^24).
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port port_id, input, 8 bits: the processor I/O address.
REQ-006 SHALL have port write_strobe, input, 1 bit: a one-cycle write qualifier.
REQ-007 SHALL have port out_port, input, 8 bits: processor write data.
REQ-008 SHALL have port read_strobe, input, 1 bit: a one-cycle read qualifier.
REQ-009 SHALL have port in_port, output, 8 bits: processor read data.
REQ-010 SHALL have port led_out, output, 8 bits, registered: the LED drive.

Function
REQ-011 SHALL decode a write when write_strobe=1 and port_id matches a register address; writes to any other port_id SHALL be ignored.
REQ-012 SHALL implement CTRL with bit0 = EN and bit1 = MODE (0 = bounce, 1 = wrap); bits 7:2 SHALL be ignored.
REQ-013 SHALL implement an 8-bit RATE register; the step period SHALL be (RATE+1)*PRESCALE_DIV clk cycles.
REQ-014 SHALL generate a one-cycle tick when the prescaler chain reaches terminal count; a RATE write SHALL clear both counters in the same cycle.
REQ-015 SHALL implement FSM states IDLE, LEFT and RIGHT.
REQ-016 In IDLE, SHALL hold led_out=8'h00 and keep the prescaler cleared.
REQ-017 On IDLE with EN=1, SHALL go to LEFT on the next cycle with led_out=8'h01; the first tick SHALL follow one full step period later.
REQ-018 In LEFT on a tick, SHALL shift led_out left by 1; at 8'h80 with MODE=0 it SHALL go to RIGHT with led_out=8'h40, and with MODE=1 it SHALL stay in LEFT with led_out=8'h01.
REQ-019 In RIGHT on a tick, SHALL shift led_out right by 1; at 8'h01 it SHALL go to LEFT with led_out=8'h02.
REQ-020 SHALL keep exactly one led_out bit set at all times outside IDLE.
REQ-021 SHALL increment an 8-bit SWEEPS counter, wrapping 255->0, on each reversal in bounce mode or each wrap in wrap mode.
REQ-022 When EN=0 is written in any state, SHALL go to IDLE on the next cycle, with led_out=0 and SWEEPS cleared.
REQ-023 When a MODE change occurs mid-scan, SHALL apply it at the next end-of-travel; a RIGHT-state sweep in progress SHALL complete its travel.
REQ-024 When a CTRL write and a tick occur in the same cycle, the CTRL write SHALL take priority and the tick SHALL be discarded.

Reset
REQ-025 On reset=1 at a clk edge, SHALL set CTRL=0, RATE=0, SWEEPS=0, prescaler=0, state=IDLE, led_out=8'h00 and in_port=8'h00.
REQ-026 SHALL give reset priority over any simultaneous write_strobe.
REQ-027 When reset is asserted mid-scan, SHALL produce led_out=0 on the following cycle.

Configuration
REQ-028 SHALL support macro LED_SCAN_READBACK_EN.
REQ-029 When LED_SCAN_READBACK_EN is defined, in_port SHALL be registered with one-cycle latency from port_id: CTRL address returns {6'b0, MODE, EN}, RATE address returns RATE, STATUS address returns SWEEPS, and any other address returns 8'h00.
REQ-030 When LED_SCAN_READBACK_EN is defined, read_strobe at the STATUS address SHALL have no side effect.
REQ-031 When LED_SCAN_READBACK_EN is not defined, in_port SHALL be the constant 8'h00, read_strobe SHALL be unused, and no readback mux SHALL be built.

Verification (PRESCALE_DIV=4)
REQ-032 SHALL cover reset with no writes: led_out=8'h00 held for 100 cycles, state IDLE.
REQ-033 SHALL cover RATE=1, then CTRL=8'h01: led_out=01 in cycle +1, then 02 8 cycles later, then 04, continuing to 80, then 40; SWEEPS=1 after the reversal.
REQ-034 SHALL cover CTRL=8'h03, RATE=0: at led_out=80, the next tick gives led_out=01 with the state remaining LEFT and SWEEPS incrementing.
REQ-035 SHALL cover CTRL=8'h00 written at led_out=10: led_out=00 on the next cycle, and SWEEPS reads 0.
REQ-036 SHALL cover a CTRL write coinciding with a tick: led_out unchanged on that cycle, and the prescaler restarts from 0.
REQ-037 SHALL cover, with LED_SCAN_READBACK_EN defined, port_id=PORT_BASE+1 after RATE=8'h5A: in_port=8'h5A one cycle later; without the macro, in_port=8'h00.

Source files
------------

// File: rtl/led_scan_controller.sv
// ============================================================================
// Module      : led_scan_controller
// Description : Processor-mapped LED scanner. A single lit LED walks across
//               led_out at a programmable step rate, either bouncing between
//               the ends or wrapping from bit 7 back to bit 0. Completed
//               sweeps are counted in an 8-bit SWEEPS register.
//               Optional macro LED_SCAN_READBACK_EN builds a registered
//               readback path on in_port; otherwise in_port is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_scan_controller #(
    parameter logic [7:0] PORT_BASE    = 8'h10,
    parameter int         PRESCALE_DIV = 65536
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_id,
    input  logic       write_strobe,
    input  logic [7:0] out_port,
    input  logic       read_strobe,
    output logic [7:0] in_port,
    output logic [7:0] led_out
);

    // Register map
    localparam logic [7:0]  c_ADDR_CTRL   = PORT_BASE;
    localparam logic [7:0]  c_ADDR_RATE   = PORT_BASE + 8'd1;
    localparam logic [7:0]  c_ADDR_STATUS = PORT_BASE + 8'd2;

    // Last value of the base prescaler (counts 0 .. PRESCALE_DIV-1)
    localparam logic [23:0] c_PRE_LAST    = 24'(PRESCALE_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LEFT  = 2'b01,
        S_RIGHT = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_en;
    logic        r_mode;
    logic [7:0]  r_rate;
    logic [7:0]  r_sweeps;
    logic [7:0]  r_led;
    logic [23:0] r_pre;
    logic [7:0]  r_step;

    logic [7:0]  w_led_nxt;
    logic [7:0]  w_sweeps_nxt;
    logic        w_ctrl_we;
    logic        w_rate_we;
    logic        w_en_nxt;
    logic        w_pre_term;
    logic        w_tick;
    logic        w_unused_read_strobe;

    // Reads never have side effects, so the read qualifier is not needed
    assign w_unused_read_strobe = read_strobe;

    assign w_ctrl_we  = write_strobe && (port_id == c_ADDR_CTRL);
    assign w_rate_we  = write_strobe && (port_id == c_ADDR_RATE);

    // EN as seen this cycle, including a CTRL write landing right now
    assign w_en_nxt   = w_ctrl_we ? out_port[0] : r_en;

    // Terminal count of the prescaler chain; a CTRL write swallows the tick
    assign w_pre_term = (r_pre == c_PRE_LAST) && (r_step == r_rate);
    assign w_tick     = (r_state != S_IDLE) && w_pre_term && !w_ctrl_we;

    assign led_out    = r_led;

    // Programmable registers: CTRL (EN, MODE) and RATE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en   <= 1'b0;
            r_mode <= 1'b0;
            r_rate <= 8'h00;
        end else begin
            if (w_ctrl_we) begin
                r_en   <= out_port[0];
                r_mode <= out_port[1];
            end
            if (w_rate_we) begin
                r_rate <= out_port;
            end
        end
    end

    // Prescaler chain: base divider then RATE+1 step counter, restarted on any register write or while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre  <= 24'd0;
            r_step <= 8'd0;
        end else if ((r_state == S_IDLE) || w_ctrl_we || w_rate_we) begin
            r_pre  <= 24'd0;
            r_step <= 8'd0;
        end else if (r_pre == c_PRE_LAST) begin
            r_pre  <= 24'd0;
            r_step <= (r_step == r_rate) ? 8'd0 : r_step + 8'd1;
        end else begin
            r_pre  <= r_pre + 24'd1;
        end
    end

    // Scan state, LED pattern and sweep counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_led    <= 8'h00;
            r_sweeps <= 8'h00;
        end else begin
            r_state  <= w_state_nxt;
            r_led    <= w_led_nxt;
            r_sweeps <= w_sweeps_nxt;
        end
    end

    // Next-state logic: walk the lit LED on each tick, reverse or wrap at the ends
    always_comb begin
        w_state_nxt  = r_state;
        w_led_nxt    = r_led;
        w_sweeps_nxt = r_sweeps;

        if (w_ctrl_we && !out_port[0]) begin
            // Disabling always wins, from any state
            w_state_nxt  = S_IDLE;
            w_led_nxt    = 8'h00;
            w_sweeps_nxt = 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_led_nxt = 8'h00;
                    if (w_en_nxt) begin
                        w_state_nxt = S_LEFT;
                        w_led_nxt   = 8'h01;
                    end
                end

                S_LEFT: begin
                    if (w_tick) begin
                        if (r_led == 8'h80) begin
                            // End of travel: MODE is sampled only here
                            w_sweeps_nxt = r_sweeps + 8'd1;
                            if (r_mode) begin
                                w_led_nxt = 8'h01;
                            end else begin
                                w_state_nxt = S_RIGHT;
                                w_led_nxt   = 8'h40;
                            end
                        end else begin
                            w_led_nxt = r_led << 1;
                        end
                    end
                end

                S_RIGHT: begin
                    // A rightward sweep always finishes, even if MODE changed
                    if (w_tick) begin
                        if (r_led == 8'h01) begin
                            w_state_nxt  = S_LEFT;
                            w_led_nxt    = 8'h02;
                            w_sweeps_nxt = r_sweeps + 8'd1;
                        end else begin
                            w_led_nxt = r_led >> 1;
                        end
                    end
                end

                default: begin
                    w_state_nxt = S_IDLE;
                    w_led_nxt   = 8'h00;
                end
            endcase
        end
    end

`ifdef LED_SCAN_READBACK_EN
    // Registered readback mux, one cycle behind port_id
    always_ff @(posedge clk) begin
        if (reset) begin
            in_port <= 8'h00;
        end else begin
            case (port_id)
                c_ADDR_CTRL:   in_port <= {6'b000000, r_mode, r_en};
                c_ADDR_RATE:   in_port <= r_rate;
                c_ADDR_STATUS: in_port <= r_sweeps;
                default:       in_port <= 8'h00;
            endcase
        end
    end
`else
    assign in_port = 8'h00;
`endif

endmodule

`default_nettype wire
